// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer in front of the CSR file.
// It watches the commit-stage instruction for ecall, illegal instruction,
// mret and a synchronised machine timer interrupt, then emits a single
// CSR write strobe, followed by a single fetch redirect.
//
// Sequence for an accepted event (accept in cycle N):
//   N   : ex_kill squashes the commit and the CSR images are captured
//   N+1 : excp_enter (trap) or excp_exit (mret), with the write data driven
//   N+2 : redirect_valid with redirect_pc
//   N+3 : ex_ready is high again
//
// Handshake: an event is accepted when ex_valid and ex_ready are both high
// in the same cycle. While ex_ready is low, ex_valid is ignored and upstream
// keeps holding the instruction until it is accepted.
//
// Optional build macro TRAP_VECTORED_EN: when it is defined and
// mtvec[1:0]==2'b01, interrupts vector to base + 4*cause. Without it,
// every trap goes to the mtvec base.
module trap_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic [31:0] ex_inst,
    input  logic        ex_ecall,
    input  logic        ex_mret,
    input  logic        ex_illegal,
    input  logic        timer_irq,
    input  logic [63:0] mstatus_rd_data,
    input  logic [63:0] mie_rd_data,
    input  logic [63:0] mtvec_rd_data,
    input  logic [63:0] mepc_rd_data,
    output logic        ex_ready,
    output logic        ex_kill,
    output logic        excp_enter,
    output logic        excp_exit,
    output logic [63:0] mstatus_wr_data,
    output logic [63:0] mepc_wr_data,
    output logic [63:0] mcause_wr_data,
    output logic [63:0] mtval_wr_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        mip_mtip,
    output logic [1:0]  dbg_state_o
);

    // Reject illegal parameter settings at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RESET_PC_UNUSED != 0) begin : g_bad_param
        $error("trap_ctrl: SYNC_STAGES must be 2..4 and RESET_PC_UNUSED must be 0");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTER    = 2'd1,
        EXIT     = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    localparam logic [63:0] CAUSE_TIMER   = {1'b1, 63'd7};
    localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [63:0] CAUSE_ECALL   = 64'd11;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mepc_q,    mepc_d;
    logic [63:0] mcause_q,  mcause_d;
    logic [63:0] mtval_q,   mtval_d;
    logic [63:0] redirect_q, redirect_d;

    logic        irq_take;
    logic        accept;
    logic        is_trap;
    logic        vec_sel;
    logic [63:0] trap_base;
    logic [63:0] trap_target;

    // Timer interrupt crosses into the clock domain through a plain flop chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], timer_irq};
        end
    end

    assign mip_mtip = sync_q[SYNC_STAGES-1];
    assign irq_take = mip_mtip & mstatus_rd_data[3] & mie_rd_data[7];

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_trap  = irq_take | ex_illegal | ex_ecall;

    // Gated by rst so the kill stays quiet while the block is held in reset.
    assign ex_kill  = rst & accept & (is_trap | ex_mret);

    assign dbg_state_o = state_q;

    // Vectored interrupt selection; exceptions always land on the base.
`ifdef TRAP_VECTORED_EN
    assign vec_sel = (mtvec_rd_data[1:0] == 2'b01) & mcause_q[63];
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_rd_data[1:0];
    assign vec_sel = 1'b0;
`endif

    assign trap_base   = {mtvec_rd_data[63:2], 2'b00};
    assign trap_target = vec_sel ? (trap_base + {mcause_q[61:0], 2'b00}) : trap_base;

    // Bits of these inputs carry no meaning for the trap sequence.
    logic unused_inputs;
    assign unused_inputs = ^{mie_rd_data[63:8], mie_rd_data[6:0], ex_pc[1:0]};

    // Capture the CSR images for the accepted event; hold them otherwise.
    always_comb begin
        mstatus_d = mstatus_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        if (accept) begin
            if (is_trap) begin
                mstatus_d        = mstatus_rd_data;
                mstatus_d[7]     = mstatus_rd_data[3];
                mstatus_d[3]     = 1'b0;
                mstatus_d[12:11] = 2'b11;
                mepc_d           = {ex_pc[63:2], 2'b00};
                if (irq_take) begin
                    mcause_d = CAUSE_TIMER;
                    mtval_d  = 64'd0;
                end else if (ex_illegal) begin
                    mcause_d = CAUSE_ILLEGAL;
                    mtval_d  = {32'd0, ex_inst};
                end else begin
                    mcause_d = CAUSE_ECALL;
                    mtval_d  = 64'd0;
                end
            end else if (ex_mret) begin
                mstatus_d        = mstatus_rd_data;
                mstatus_d[3]     = mstatus_rd_data[7];
                mstatus_d[7]     = 1'b1;
                mstatus_d[12:11] = 2'b11;
                mepc_d           = 64'd0;
                mcause_d         = 64'd0;
                mtval_d          = 64'd0;
            end
        end
    end

    // Latch the redirect target during the CSR strobe cycle.
    always_comb begin
        redirect_d = redirect_q;
        case (state_q)
            ENTER:   redirect_d = trap_target;
            EXIT:    redirect_d = mepc_rd_data;
            default: redirect_d = redirect_q;
        endcase
    end

    // Capture and redirect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mtval_q    <= 64'd0;
            redirect_q <= 64'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            redirect_q <= redirect_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and strobes; write data is zero outside the strobe cycle.
    always_comb begin
        state_d         = state_q;
        excp_enter      = 1'b0;
        excp_exit       = 1'b0;
        redirect_valid  = 1'b0;
        mstatus_wr_data = 64'd0;
        mepc_wr_data    = 64'd0;
        mcause_wr_data  = 64'd0;
        mtval_wr_data   = 64'd0;
        redirect_pc     = 64'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_trap) begin
                        state_d = ENTER;
                    end else if (ex_mret) begin
                        state_d = EXIT;
                    end
                end
            end
            ENTER: begin
                excp_enter      = 1'b1;
                mstatus_wr_data = mstatus_q;
                mepc_wr_data    = mepc_q;
                mcause_wr_data  = mcause_q;
                mtval_wr_data   = mtval_q;
                state_d         = REDIRECT;
            end
            EXIT: begin
                excp_exit       = 1'b1;
                mstatus_wr_data = mstatus_q;
                mepc_wr_data    = mepc_q;
                mcause_wr_data  = mcause_q;
                mtval_wr_data   = mtval_q;
                state_d         = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = redirect_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
